// File: rtl/rlgl_pkg.sv
// Shared constants for the Red Light Green Light game sequencer:
// FSM state codes, LFSR geometry and the game-timer width.
package rlgl_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_GREEN     = 3'd1;
    localparam logic [2:0] ST_RED_GRACE = 3'd2;
    localparam logic [2:0] ST_RED       = 3'd3;
    localparam logic [2:0] ST_WIN       = 3'd4;
    localparam logic [2:0] ST_LOSE      = 3'd5;

    localparam int LFSR_W = 8;
    // Fibonacci taps 8,6,5,4 -> bits 7,5,4,3
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

    localparam int TIME_W = 6;

    // One step of the Fibonacci LFSR; a non-zero state never maps to zero.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/rlgl_tick_gen.sv
// Game tick generator: one-cycle tick every TICK_DIV clk cycles,
// restartable so a new game always sees a full first tick period.
module rlgl_tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: wrap at the terminal value, restart on clear.
    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rlgl_game_ctrl.sv
// Red Light Green Light game sequencer: pseudo-random lamp phases,
// a grace window after each switch to red, game timer and win/lose.
module rlgl_game_ctrl
    import rlgl_pkg::*;
#(
    parameter int                TICK_DIV   = 50000000,
    parameter int                MIN_PHASE  = 2,
    parameter int                RANGE_LOG2 = 2,
    parameter int                GRACE_CYC  = 25000000,
    parameter int                GAME_TIME  = 30,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              move,
    input  logic              finish,
    output logic              red,
    output logic              green,
    output logic              win,
    output logic              lose,
    output logic [TIME_W-1:0] time_left,
    output logic [2:0]        state_o
);

    localparam int PHASE_W = $clog2(MIN_PHASE + (1 << RANGE_LOG2));
    localparam int GRACE_W = (GRACE_CYC > 1) ? $clog2(GRACE_CYC) : 1;

    logic [2:0]         state_q, state_d;
    logic               red_q, red_d;
    logic               green_q, green_d;
    logic               win_q, win_d;
    logic               lose_q, lose_d;
    logic [TIME_W-1:0]  time_left_q, time_left_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [PHASE_W-1:0] phase_cnt_q, phase_cnt_d;
    logic [GRACE_W-1:0] grace_cnt_q, grace_cnt_d;

    logic               tick;
    logic               start_ok;
    logic               timeout;
    logic               phase_exp;
    logic [PHASE_W-1:0] phase_reload;

    assign start_ok     = start && ((state_q == ST_IDLE) || (state_q == ST_WIN) ||
                                    (state_q == ST_LOSE));
    assign timeout      = tick && (time_left_q == TIME_W'(1));
    assign phase_exp    = tick && (phase_cnt_q == PHASE_W'(1));
    assign phase_reload = PHASE_W'(MIN_PHASE) + PHASE_W'(lfsr_q[RANGE_LOG2-1:0]);

    // The tick counter restarts when a game starts so the first tick is a full period.
    rlgl_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .tick  (tick)
    );

    // Game FSM; same-cycle priority: move-in-red, finish, timeout, phase expiry.
    always_comb begin
        state_d     = state_q;
        red_d       = red_q;
        green_d     = green_q;
        win_d       = win_q;
        lose_d      = lose_q;
        time_left_d = time_left_q;
        phase_cnt_d = phase_cnt_q;
        grace_cnt_d = grace_cnt_q;
        lfsr_d      = lfsr_step(lfsr_q);

        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start) begin
                    state_d     = ST_GREEN;
                    green_d     = 1'b1;
                    red_d       = 1'b0;
                    win_d       = 1'b0;
                    lose_d      = 1'b0;
                    time_left_d = TIME_W'(GAME_TIME);
                    phase_cnt_d = phase_reload;
                end
            end
            ST_GREEN, ST_RED_GRACE, ST_RED: begin
                if ((state_q == ST_RED) && move) begin
                    state_d = ST_LOSE;
                    lose_d  = 1'b1;
                    red_d   = 1'b1;
                    green_d = 1'b0;
                end else if (finish) begin
                    // time_left freezes at its current value on a win
                    state_d = ST_WIN;
                    win_d   = 1'b1;
                    red_d   = 1'b1;
                    green_d = 1'b0;
                end else if (timeout) begin
                    state_d     = ST_LOSE;
                    lose_d      = 1'b1;
                    red_d       = 1'b1;
                    green_d     = 1'b0;
                    time_left_d = '0;
                end else begin
                    if (tick) begin
                        time_left_d = time_left_q - TIME_W'(1);
                        phase_cnt_d = phase_cnt_q - PHASE_W'(1);
                    end
                    if ((state_q == ST_RED_GRACE) && (grace_cnt_q != '0)) begin
                        grace_cnt_d = grace_cnt_q - GRACE_W'(1);
                    end
                    if (phase_exp) begin
                        phase_cnt_d = phase_reload;
                        if (state_q == ST_GREEN) begin
                            state_d     = ST_RED_GRACE;
                            red_d       = 1'b1;
                            green_d     = 1'b0;
                            grace_cnt_d = GRACE_W'(GRACE_CYC - 1);
                        end else begin
                            state_d     = ST_GREEN;
                            green_d     = 1'b1;
                            red_d       = 1'b0;
                            grace_cnt_d = '0;
                        end
                    end else if ((state_q == ST_RED_GRACE) && (grace_cnt_q == '0)) begin
                        state_d = ST_RED;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                red_d   = 1'b1;
                green_d = 1'b0;
                win_d   = 1'b0;
                lose_d  = 1'b0;
            end
        endcase
    end

    // State, lamp, result and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            red_q       <= 1'b1;
            green_q     <= 1'b0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            time_left_q <= TIME_W'(GAME_TIME);
            lfsr_q      <= LFSR_SEED;
            phase_cnt_q <= '0;
            grace_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            red_q       <= red_d;
            green_q     <= green_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
            time_left_q <= time_left_d;
            lfsr_q      <= lfsr_d;
            phase_cnt_q <= phase_cnt_d;
            grace_cnt_q <= grace_cnt_d;
        end
    end

    assign red       = red_q;
    assign green     = green_q;
    assign win       = win_q;
    assign lose      = lose_q;
    assign time_left = time_left_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_rlgl_game_ctrl.sv
// Scoreboard bench for rlgl_game_ctrl: stimulus queues expected output
// values tagged with the clock edge they apply to; a monitor compares them.
module tb_rlgl_game_ctrl;

    localparam int TICK_DIV   = 4;
    localparam int MIN_PHASE  = 2;
    localparam int RANGE_LOG2 = 2;
    localparam int GRACE_CYC  = 2;
    localparam int GAME_TIME  = 10;
    localparam logic [7:0] SEED = 8'hA5;

    localparam int S_RED = 0, S_GREEN = 1, S_WIN = 2, S_LOSE = 3, S_TIME = 4, S_STATE = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       move = 1'b0;
    logic       finish = 1'b0;
    logic       red, green, win, lose;
    logic [5:0] time_left;
    logic [2:0] state_o;

    rlgl_game_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .MIN_PHASE  (MIN_PHASE),
        .RANGE_LOG2 (RANGE_LOG2),
        .GRACE_CYC  (GRACE_CYC),
        .GAME_TIME  (GAME_TIME),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .move      (move),
        .finish    (finish),
        .red       (red),
        .green     (green),
        .win       (win),
        .lose      (lose),
        .time_left (time_left),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] lf_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [7:0] adv(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = lf_next(r);
        return r;
    endfunction

    function automatic int phase_len(input logic [7:0] v);
        return MIN_PHASE + int'(v[1:0]);
    endfunction

    // Independent LFSR model, free-running from reset like the lamp sequencer's.
    logic [7:0] lfsr_m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_m <= SEED;
        else        lfsr_m <= lf_next(lfsr_m);
    end

    typedef struct {
        int         cyc;
        int         sig;
        logic [7:0] exp;
        bit         probe;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    bit   probe_pending = 1'b0;
    event probe_ev;

    task automatic push(input int c, input int sig, input int ex, input string nm, input bit pr);
        exp_t e;
        e.cyc = c; e.sig = sig; e.exp = 8'(ex); e.probe = pr; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic expect_all(input int c, input int r, input int g, input int w, input int l,
                              input int t, input int st, input string nm, input bit pr);
        push(c, S_RED, r, {nm, ".red"}, pr);
        push(c, S_GREEN, g, {nm, ".green"}, pr);
        push(c, S_WIN, w, {nm, ".win"}, pr);
        push(c, S_LOSE, l, {nm, ".lose"}, pr);
        push(c, S_TIME, t, {nm, ".time_left"}, pr);
        push(c, S_STATE, st, {nm, ".state"}, pr);
    endtask

    function automatic logic [7:0] actual(input int sig);
        case (sig)
            S_RED:   return {7'd0, red};
            S_GREEN: return {7'd0, green};
            S_WIN:   return {7'd0, win};
            S_LOSE:  return {7'd0, lose};
            S_TIME:  return {2'd0, time_left};
            S_STATE: return {5'd0, state_o};
            default: return 8'hFF;
        endcase
    endfunction

    task automatic check_entry(input exp_t e);
        logic [7:0] a;
        a = actual(e.sig);
        checks++;
        if (a !== e.exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", e.name, e.cyc, a, e.exp);
        end
    endtask

    // Monitor: at each negedge compare entries due this cycle; probe entries on demand.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or probe_ev);
            if (probe_pending) begin
                probe_pending = 1'b0;
                while (sb.size() > 0 && sb[0].probe && sb[0].cyc == cyc) begin
                    e = sb.pop_front();
                    check_entry(e);
                end
            end else begin
                while (sb.size() > 0 &&
                       (sb[0].cyc < cyc || (sb[0].cyc == cyc && !sb[0].probe))) begin
                    e = sb.pop_front();
                    if (e.cyc < cyc) begin
                        checks++;
                        failures++;
                        $display("FAIL %s missed: due cyc=%0d now=%0d", e.name, e.cyc, cyc);
                    end else begin
                        check_entry(e);
                    end
                end
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int S, E, c0, rem, gs, st;
        logic [7:0] L;
        bit g;
        exp_t e;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state and idle, then start; the same game runs to timeout.
        c0 = cyc;
        expect_all(c0 + 1, 1, 0, 0, 0, 10, 0, "t1_reset", 1'b0);
        expect_all(c0 + 20, 1, 0, 0, 0, 10, 0, "t1_idle", 1'b0);
        wait_until(c0 + 20);
        S = cyc + 1;
        L = lfsr_m;
        g = 1'b1;
        rem = phase_len(L);
        gs = -100;
        for (int c = S; c < S + 40; c++) begin
            if (c > S && ((c - S) % TICK_DIV) == 0) begin
                rem--;
                if (rem == 0) begin
                    g = !g;
                    rem = phase_len(adv(L, c - S));
                    if (!g) gs = c;
                end
            end
            st = g ? 1 : ((c - gs < GRACE_CYC) ? 2 : 3);
            push(c, S_GREEN, int'(g), "t2_run.green", 1'b0);
            push(c, S_RED, int'(!g), "t2_run.red", 1'b0);
            push(c, S_TIME, GAME_TIME - (c - S) / TICK_DIV, "t2_run.time_left", 1'b0);
            push(c, S_STATE, st, "t2_run.state", 1'b0);
        end
        expect_all(S + 40, 1, 0, 0, 1, 0, 5, "t2_timeout", 1'b0);
        expect_all(S + 42, 1, 0, 0, 1, 0, 5, "t2_lose_ignores_inputs", 1'b0);
        pulse_start();
        wait_until(S + 41);
        finish = 1'b1;
        move = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        move = 1'b0;
        wait_until(S + 43);

        // finish on the same edge as the final timeout tick
        S = cyc + 1;
        push(S + 40, S_WIN, 1, "t5a_finish_vs_timeout.win", 1'b0);
        push(S + 40, S_LOSE, 0, "t5a_finish_vs_timeout.lose", 1'b0);
        push(S + 40, S_STATE, 4, "t5a_finish_vs_timeout.state", 1'b0);
        pulse_start();
        wait_until(S + 39);
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        wait_until(S + 41);

        // finish in GREEN at time_left=7; needs a 5-tick first green phase
        for (int i = 0; i < 64 && lfsr_m[1:0] != 2'b11; i++) @(negedge clk);
        if (lfsr_m[1:0] != 2'b11) begin
            checks++;
            failures++;
            $display("FAIL t4_lfsr_wait bound expired lfsr=%0h required low bits=3", lfsr_m);
        end
        S = cyc + 1;
        push(S + 12, S_TIME, 7, "t4_pre.time_left", 1'b0);
        push(S + 12, S_STATE, 1, "t4_pre.state", 1'b0);
        expect_all(S + 13, 1, 0, 1, 0, 7, 4, "t4_win", 1'b0);
        push(S + 18, S_TIME, 7, "t4_frozen.time_left", 1'b0);
        push(S + 18, S_WIN, 1, "t4_frozen.win", 1'b0);
        expect_all(S + 21, 0, 1, 0, 0, 10, 1, "t4_restart", 1'b0);
        push(S + 22, S_WIN, 1, "t4_rewin.win", 1'b0);
        push(S + 22, S_STATE, 4, "t4_rewin.state", 1'b0);
        pulse_start();
        wait_until(S + 12);
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        wait_until(S + 20);
        pulse_start();
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        wait_until(S + 23);

        // movement ignored during grace, punished in RED
        S = cyc + 1;
        L = lfsr_m;
        E = S + TICK_DIV * phase_len(L);
        push(E - 1, S_STATE, 1, "t3_green.state", 1'b0);
        push(E, S_STATE, 2, "t3_grace0.state", 1'b0);
        push(E, S_RED, 1, "t3_grace0.red", 1'b0);
        push(E, S_GREEN, 0, "t3_grace0.green", 1'b0);
        push(E + 1, S_STATE, 2, "t3_grace1.state", 1'b0);
        push(E + 1, S_LOSE, 0, "t3_grace1.lose", 1'b0);
        push(E + 2, S_STATE, 3, "t3_red.state", 1'b0);
        push(E + 2, S_LOSE, 0, "t3_red.lose", 1'b0);
        push(E + 3, S_LOSE, 0, "t3_red2.lose", 1'b0);
        push(E + 4, S_LOSE, 1, "t3_move_red.lose", 1'b0);
        push(E + 4, S_STATE, 5, "t3_move_red.state", 1'b0);
        pulse_start();
        wait_until(E);
        move = 1'b1;
        @(negedge clk);
        move = 1'b0;
        wait_until(E + 3);
        move = 1'b1;
        @(negedge clk);
        move = 1'b0;
        wait_until(E + 5);

        // finish together with move in RED loses
        S = cyc + 1;
        L = lfsr_m;
        E = S + TICK_DIV * phase_len(L);
        push(E + 4, S_LOSE, 1, "t5b_move_finish.lose", 1'b0);
        push(E + 4, S_WIN, 0, "t5b_move_finish.win", 1'b0);
        push(E + 4, S_STATE, 5, "t5b_move_finish.state", 1'b0);
        pulse_start();
        wait_until(E + 3);
        move = 1'b1;
        finish = 1'b1;
        @(negedge clk);
        move = 1'b0;
        finish = 1'b0;
        wait_until(E + 5);

        // start ignored in GREEN, then asynchronous reset in RED
        S = cyc + 1;
        L = lfsr_m;
        E = S + TICK_DIV * phase_len(L);
        push(S + 5, S_TIME, 9, "t6_start_ignored.time_left", 1'b0);
        push(S + 5, S_STATE, 1, "t6_start_ignored.state", 1'b0);
        push(S + 8, S_TIME, 8, "t6_tick_kept.time_left", 1'b0);
        push(E + 3, S_STATE, 3, "t6_in_red.state", 1'b0);
        expect_all(E + 3, 1, 0, 0, 0, 10, 0, "t6_async_reset", 1'b1);
        pulse_start();
        wait_until(S + 4);
        pulse_start();
        wait_until(E + 3);
        #2;
        rst_n = 1'b0;
        #1;
        probe_pending = 1'b1;
        ->probe_ev;
        @(negedge clk);
        rst_n = 1'b1;
        c0 = cyc;
        expect_all(c0 + 2, 1, 0, 0, 0, 10, 0, "t6_after_reset", 1'b0);
        wait_until(c0 + 4);

        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL %s never compared: due cyc=%0d", e.name, e.cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rlgl_game_ctrl.md
Name: rlgl_game_ctrl

Overview:
Game sequencer for the Red Light Green Light display.
- Alternates the red/green lamp outputs with pseudo-random phase lengths.
- Enforces a reaction grace window after each switch to red.
- Monitors the player's move/finish inputs and the overall game timer, then declares win or lose.
- Single clock domain: replaces the derived-clock lamp toggler with a clock-enable tick, so every flop runs on clk.

Parameters:
TICK_DIV, 50000000, clk cycles per game tick (1 s at 50 MHz); must be >= 2
MIN_PHASE, 2, minimum phase length in ticks; must be >= 1
RANGE_LOG2, 2, phase length = MIN_PHASE + lfsr[RANGE_LOG2-1:0], giving 2..5 ticks by default
GRACE_CYC, 25000000, clk cycles after entering red during which movement is ignored; must be < MIN_PHASE*TICK_DIV
GAME_TIME, 30, game length in ticks; 1..63
LFSR_SEED, 8'hA5, reset value of the LFSR; must be non-zero

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse, begins a game; accepted only in IDLE, WIN or LOSE
move  in  1  level, player moving; already synchronised/debounced upstream
finish  in  1  single-cycle pulse, player reached the line
red  out  1  red lamp
green  out  1  green lamp
win  out  1  game won; held until the next start
lose  out  1  game lost; held until the next start
time_left  out  6  remaining game ticks
state_o  out  3  current FSM state code, for display/debug

Behaviour:
- Reset (async assert, sync release): state IDLE, red=1, green=0, win=0, lose=0, time_left=GAME_TIME, lfsr=LFSR_SEED, all counters 0. Reset mid-game aborts to IDLE immediately.
- All outputs are registered. An input sampled at edge N is reflected at edge N+1.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every clk cycle in every state; never reaches 0.
- Tick: rlgl_tick_gen counter 0..TICK_DIV-1. tick=1 for one cycle when count==TICK_DIV-1. The counter is cleared on the cycle start is accepted.
- States and codes: IDLE=0, GREEN=1, RED_GRACE=2, RED=3, WIN=4, LOSE=5.
- IDLE / WIN / LOSE + start → GREEN, with:
  - green=1, red=0, win=0, lose=0, time_left=GAME_TIME
  - phase_cnt = MIN_PHASE + lfsr[RANGE_LOG2-1:0]
- GREEN:
  - each tick decrements phase_cnt.
  - tick with phase_cnt==1 → RED_GRACE: red=1, green=0, phase_cnt reloaded from the LFSR, grace_cnt=GRACE_CYC-1.
- RED_GRACE:
  - grace_cnt decrements every cycle; move is ignored.
  - grace_cnt==0 → RED.
  - Ticks keep decrementing phase_cnt; the grace window is part of the red phase.
- RED:
  - move=1 → LOSE.
  - tick with phase_cnt==1 → GREEN, with phase_cnt reloaded.
- Game timer: in GREEN, RED_GRACE and RED, each tick decrements time_left. Tick with time_left==1 → LOSE, time_left=0.
- finish in GREEN or RED_GRACE → WIN. finish in RED with move=0 → WIN.
- Same-cycle priority, highest first:
  1. RED and move=1 → LOSE
  2. finish → WIN
  3. timeout → LOSE
  4. phase expiry
- WIN/LOSE: red=1, green=0. time_left is frozen. start begins a new game.
- start in GREEN, RED_GRACE or RED is ignored. move and finish are ignored in IDLE, WIN and LOSE.

Decomposition:
- Package rlgl_pkg holds:
  - state encodings (IDLE..LOSE)
  - LFSR width and tap mask
  - TIME_W=6
- One sub-module: rlgl_tick_gen (params TICK_DIV; ports clk, rst_n, clr, tick).
- The LFSR stays inline in rlgl_game_ctrl.

Test Plan:
All scenarios use TICK_DIV=4, MIN_PHASE=2, RANGE_LOG2=2, GRACE_CYC=2, GAME_TIME=10, unless noted otherwise.
1. Reset, then idle 20 cycles → red=1, green=0, win=0, lose=0, time_left=10, state_o=0. Then start pulse → next cycle green=1, red=0, state_o=1.
2. Start, hold move=0, no finish → lamps alternate; every phase lasts 2..5 ticks and matches the LFSR model exactly. After 40 cycles: lose=1, time_left=0, state_o=5.
3. Start; assert move=1 on the first RED_GRACE cycle and drop it before grace ends → no lose; state reaches 3. Assert move=1 in RED → lose=1 on the next cycle.
4. Start; finish pulse in GREEN at time_left=7 → win=1, red=1, time_left held at 7. Start again → win=0, time_left=10, green=1.
5. Simultaneous cases:
   - finish on the same cycle as the final timeout tick → win=1.
   - finish with move=1 in RED → lose=1.
6. Drop rst_n mid-RED, asynchronously between edges → red=1, green=0, state_o=0 before the next edge. start pulses during GREEN are ignored: time_left is not reloaded.
